// File: rtl/pdm_pkg.sv
// Shared constants and state encoding for the PCM-to-PDM modulator.
package pdm_pkg;

  localparam int unsigned PCM_W_DEF = 16;
  localparam int unsigned OSR_DEF   = 64;

  function automatic int unsigned fb_mag(input int unsigned pcm_w);
    return 32'd1 << (pcm_w - 32'd1);
  endfunction

  // Loop feedback magnitude: one full-scale PCM step, 2^(PCM_W-1).
  localparam int unsigned FB_MAG_DEF = fb_mag(PCM_W_DEF);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/ds2_loop.sv
// Second-order delta-sigma loop: two saturating integrators and a sign comparator.
module ds2_loop
  import pdm_pkg::*;
#(
  parameter int unsigned PCM_W  = PCM_W_DEF,
  parameter int unsigned ACC_W  = PCM_W + 6,
  parameter int unsigned FB_MAG = FB_MAG_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en_i,
  input  logic                    clr_i,
  input  logic signed [PCM_W-1:0] sample_i,
  input  logic                    fb_i,
  output logic                    bit_o_c
);

  localparam int unsigned EXT_W = ACC_W + 2;
  localparam logic signed [EXT_W-1:0] FB_P   = EXT_W'(FB_MAG);
  localparam logic signed [EXT_W-1:0] SAT_HI = {3'b000, {(ACC_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] SAT_LO = {3'b111, {(ACC_W-1){1'b0}}};

  logic signed [ACC_W-1:0] i1_q, i1_d, i2_q, i2_d;
  logic signed [EXT_W-1:0] x_c, fb_c, sum1_c, sum2_c;

  function automatic logic signed [ACC_W-1:0] sat(input logic signed [EXT_W-1:0] v);
    if (v > SAT_HI) begin
      return SAT_HI[ACC_W-1:0];
    end else if (v < SAT_LO) begin
      return SAT_LO[ACC_W-1:0];
    end else begin
      return v[ACC_W-1:0];
    end
  endfunction

  // Input is halved (-6 dB) so the loop never runs out of feedback headroom.
  always_comb begin
    x_c     = {{(EXT_W-PCM_W+1){sample_i[PCM_W-1]}}, sample_i[PCM_W-1:1]};
    fb_c    = fb_i ? FB_P : -FB_P;
    sum1_c  = {{2{i1_q[ACC_W-1]}}, i1_q} + x_c - fb_c;
    i1_d    = sat(sum1_c);
    sum2_c  = {{2{i2_q[ACC_W-1]}}, i2_q} + {{2{i1_d[ACC_W-1]}}, i1_d} - fb_c;
    i2_d    = sat(sum2_c);
    bit_o_c = ~i2_d[ACC_W-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i1_q <= '0;
      i2_q <= '0;
    end else if (clr_i) begin
      i1_q <= '0;
      i2_q <= '0;
    end else if (en_i) begin
      i1_q <= i1_d;
      i2_q <= i2_d;
    end
  end

endmodule

// File: rtl/pdm_modulator.sv
// PCM sample stream to 1-bit PDM: holding buffer, zero-order hold phase counter and run/idle FSM.
module pdm_modulator
  import pdm_pkg::*;
#(
  parameter int unsigned PCM_W = PCM_W_DEF,
  parameter int unsigned OSR   = OSR_DEF,
  parameter int unsigned ACC_W = PCM_W + 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [PCM_W-1:0] pcm_data,
  input  logic                    pcm_valid,
  output logic                    pcm_ready,
  output logic                    pdm_out,
  output logic                    sample_tick,
  output logic                    underrun,
  output logic                    running
);

  localparam int unsigned PHASE_W = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(OSR - 1);

  state_e                  state_q, state_d;
  logic signed [PCM_W-1:0] buf_q, buf_d, cur_q, cur_d;
  logic                    buf_full_q, buf_full_d;
  logic [PHASE_W-1:0]      phase_q, phase_d;
  logic                    pdm_q, pdm_d;
  logic                    tick_q, tick_d;
  logic                    underrun_q, underrun_d;
  logic                    running_q, running_d;
  logic                    load_c, accept_c, clr_c, wrap_c, loop_bit_c;

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    cur_d      = cur_q;
    phase_d    = phase_q;
    pdm_d      = pdm_q;
    tick_d     = 1'b0;
    underrun_d = 1'b0;
    load_c     = 1'b0;
    clr_c      = 1'b0;
    wrap_c     = (phase_q == PHASE_LAST);

    unique case (state_q)
      IDLE: begin
        pdm_d   = ~pdm_q;
        phase_d = '0;
        if (buf_full_q) begin
          load_c  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        pdm_d   = loop_bit_c;
        phase_d = wrap_c ? '0 : phase_q + PHASE_W'(1);
        if (wrap_c) begin
          if (buf_full_q) begin
            load_c = 1'b1;
          end else begin
            // Starved: drop to idle with a clean loop so the toggle restarts at 0.
            underrun_d = 1'b1;
            state_d    = IDLE;
            clr_c      = 1'b1;
            cur_d      = '0;
            pdm_d      = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load_c) begin
      cur_d   = buf_q;
      tick_d  = 1'b1;
      phase_d = '0;
    end

    // A load frees the buffer in the same cycle, so a new sample can slip in behind it.
    pcm_ready = !buf_full_q || load_c;
    accept_c  = pcm_valid && pcm_ready;
    if (accept_c) begin
      buf_d      = pcm_data;
      buf_full_d = 1'b1;
    end else if (load_c) begin
      buf_full_d = 1'b0;
    end

    running_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      cur_q      <= '0;
      phase_q    <= '0;
      pdm_q      <= 1'b0;
      tick_q     <= 1'b0;
      underrun_q <= 1'b0;
      running_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      cur_q      <= cur_d;
      phase_q    <= phase_d;
      pdm_q      <= pdm_d;
      tick_q     <= tick_d;
      underrun_q <= underrun_d;
      running_q  <= running_d;
    end
  end

  ds2_loop #(
    .PCM_W (PCM_W),
    .ACC_W (ACC_W),
    .FB_MAG(fb_mag(PCM_W))
  ) u_loop (
    .clk     (clk),
    .rst_n   (reset),
    .en_i    (running_q),
    .clr_i   (clr_c),
    .sample_i(cur_q),
    .fb_i    (pdm_q),
    .bit_o_c (loop_bit_c)
  );

  assign pdm_out     = pdm_q;
  assign sample_tick = tick_q;
  assign underrun    = underrun_q;
  assign running     = running_q;

endmodule

// File: tb/tb_pdm_modulator.sv
// Directed bench for pdm_modulator: handshake timing, per-sample ones density, underrun and reset.
`timescale 1ns/1ps
module tb_pdm_modulator;

  localparam int PCM_W = 16;
  localparam int OSR   = 64;

  typedef struct {
    real center;
    real tol;
    bit  dens;
  } exp_t;

  logic                    clk;
  logic                    reset;
  logic signed [PCM_W-1:0] pcm_data;
  logic                    pcm_valid;
  logic                    pcm_ready;
  logic                    pdm_out;
  logic                    sample_tick;
  logic                    underrun;
  logic                    running;

  int   total     = 0;
  int   bad       = 0;
  int   cyc       = 0;
  int   last_tick = 0;
  int   last_acc  = 0;
  int   tick_cnt  = 0;
  int   ones      = 0;
  int   nbits     = 0;
  bit   win_on    = 1'b0;
  bit   gap_reset = 1'b1;
  exp_t sb[$];
  exp_t cur_e;

  pdm_modulator dut (
    .clk        (clk),
    .reset      (reset),
    .pcm_data   (pcm_data),
    .pcm_valid  (pcm_valid),
    .pcm_ready  (pcm_ready),
    .pdm_out    (pdm_out),
    .sample_tick(sample_tick),
    .underrun   (underrun),
    .running    (running)
  );

  initial begin
    clk = 1'b0;
    forever #163 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  initial begin
    #20000000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    total++;
    assert (obs >= lo && obs <= hi) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Offer one sample; on acceptance push its expected ones-per-window into the scoreboard.
  task automatic send(input logic signed [PCM_W-1:0] d, input bit dens, input real tol,
                      input bit gap);
    int   waitc;
    exp_t e;
    waitc     = 0;
    pcm_data  = d;
    pcm_valid = 1'b1;
    while (pcm_ready !== 1'b1 && waitc < 4 * OSR) begin
      @(negedge clk);
      waitc++;
    end
    chk("accept_ready", pcm_ready, 1);
    if (pcm_ready === 1'b1) begin
      e.center = (real'(OSR) / 2.0) * (1.0 + real'(d >>> 1) / 32768.0);
      e.tol    = tol;
      e.dens   = dens;
      sb.push_back(e);
      if (gap) chk("accept_gap", cyc - last_acc, OSR);
      last_acc = cyc;
    end
    @(negedge clk);
  endtask

  task automatic wait_underrun(input string tag);
    int waitc;
    waitc = 0;
    while (underrun !== 1'b1 && waitc < 4 * OSR) begin
      @(negedge clk);
      waitc++;
    end
    chk(tag, underrun, 1);
  endtask

  // Scoreboard consumer: each tick pops one sample and counts ones over the next OSR bits.
  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      win_on    = 1'b0;
      gap_reset = 1'b1;
      sb.delete();
    end else begin
      if (win_on) begin
        ones += int'(pdm_out);
        nbits++;
        if (nbits == OSR) begin
          win_on = 1'b0;
          if (cur_e.dens)
            chk_rng("density", ones, $rtoi($ceil(cur_e.center - cur_e.tol)),
                    $rtoi($floor(cur_e.center + cur_e.tol)));
        end
      end
      if (underrun === 1'b1) gap_reset = 1'b1;
      if (sample_tick === 1'b1) begin
        if (!gap_reset) chk("tick_period", cyc - last_tick, OSR);
        gap_reset = 1'b0;
        chk("tick_expected", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          cur_e  = sb.pop_front();
          win_on = 1'b1;
          ones   = 0;
          nbits  = 0;
        end
        last_tick = cyc;
        tick_cnt++;
      end
    end
  end

  initial begin
    int waitc;
    int tc0;
    reset     = 1'b1;
    pcm_valid = 1'b0;
    pcm_data  = '0;
    #10 reset = 1'b0;
    #1000;
    @(negedge clk);
    chk("rst_pdm", pdm_out, 0);
    chk("rst_running", running, 0);
    chk("rst_tick", sample_tick, 0);
    chk("rst_underrun", underrun, 0);
    reset = 1'b1;
    #1;
    chk("rel_ready", pcm_ready, 1);
    chk("rel_pdm", pdm_out, 0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("idle_toggle", pdm_out, (k + 1) % 2);
    end

    // Latency: not running one cycle after accept, running with tick the cycle after.
    send(16'sh0000, 1'b0, 0.0, 1'b0);
    chk("lat_tick_a", sample_tick, 0);
    chk("lat_run_a", running, 0);
    send(16'sh0000, 1'b0, 0.0, 1'b0);
    chk("lat_tick_b", sample_tick, 1);
    chk("lat_run_b", running, 1);

    // Continuous streams; valid never drops so every later accept is one OSR apart.
    for (int i = 2; i < 10; i++) send(16'sh0000, i >= 4, 2.0, 1'b1);
    for (int i = 0; i < 8; i++)  send(16'sh7FFF, i >= 3, 2.0, 1'b1);
    for (int i = 0; i < 8; i++)  send(16'sh8000, i >= 3, 2.0, 1'b1);
    for (int i = 0; i < 8; i++)
      send((i % 2 == 0) ? 16'sh6000 : -16'sh6000, i >= 1, 4.0, 1'b1);
    pcm_valid = 1'b0;

    wait_underrun("stream_underrun");
    chk("stream_und_dist", cyc - last_tick, OSR);
    chk("stream_und_running", running, 0);
    chk("stream_und_pdm", pdm_out, 0);
    @(negedge clk);
    chk("resume_toggle_1", pdm_out, 1);
    @(negedge clk);
    chk("resume_toggle_0", pdm_out, 0);
    chk("sb_drained", sb.size(), 0);

    // Three samples then starve.
    tc0 = tick_cnt;
    for (int i = 0; i < 3; i++) send(16'sh2000, 1'b0, 0.0, 1'b0);
    pcm_valid = 1'b0;
    wait_underrun("three_underrun");
    chk("three_ticks", tick_cnt - tc0, 3);
    chk("three_und_dist", cyc - last_tick, OSR);
    chk("three_running", running, 0);

    // Sample arriving on the underrun decision cycle: underrun still fires, then it loads.
    tc0 = tick_cnt;
    send(16'sh1000, 1'b0, 0.0, 1'b0);
    pcm_valid = 1'b0;
    waitc = 0;
    while (tick_cnt == tc0 && waitc < 4 * OSR) begin
      @(negedge clk);
      waitc++;
    end
    chk("corner_first_tick", tick_cnt - tc0, 1);
    waitc = 0;
    while (cyc != last_tick + OSR - 1 && waitc < 2 * OSR) begin
      @(negedge clk);
      waitc++;
    end
    send(16'sh1000, 1'b0, 0.0, 1'b0);
    pcm_valid = 1'b0;
    chk("corner_underrun", underrun, 1);
    chk("corner_running_lo", running, 0);
    @(negedge clk);
    chk("corner_tick", sample_tick, 1);
    chk("corner_running_hi", running, 1);
    wait_underrun("corner_underrun2");
    chk("corner_und_dist", cyc - last_tick, OSR);

    // Reset at phase 30 with one sample still buffered.
    send(16'sh2000, 1'b0, 0.0, 1'b0);
    send(16'sh2000, 1'b0, 0.0, 1'b0);
    pcm_valid = 1'b0;
    @(negedge clk);
    waitc = 0;
    while (cyc != last_tick + 30 && waitc < 2 * OSR) begin
      @(negedge clk);
      waitc++;
    end
    chk("rstmid_phase", cyc - last_tick, 30);
    chk("rstmid_ready_before", pcm_ready, 0);
    #5 reset = 1'b0;
    #1;
    chk("rstmid_pdm", pdm_out, 0);
    chk("rstmid_running", running, 0);
    chk("rstmid_tick", sample_tick, 0);
    chk("rstmid_underrun", underrun, 0);
    chk("rstmid_ready", pcm_ready, 1);
    tc0 = tick_cnt;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rstmid_toggle", pdm_out, 1);
    repeat (2 * OSR) @(negedge clk);
    chk("rstmid_no_tick", tick_cnt - tc0, 0);
    chk("rstmid_idle", running, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
